// File: rtl/ro_pair_compare.sv
// RO PUF pair measurement: enables both oscillators, counts edges over a window, compares.
// Optional macro RO_CMP_TIE_EN adds a registered tie output (count_a == count_b).
`timescale 1ns/1ps
module ro_pair_compare #(
    parameter int WINDOW = 1024,
    parameter int SETTLE = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic             ro_enable,
    output logic             busy,
    output logic             done,
    output logic             response,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b
`ifdef RO_CMP_TIE_EN
    ,
    output logic             tie
`endif
);

    localparam int WC_W = $clog2(WINDOW + SETTLE) + 1;
    localparam logic [WC_W-1:0] SETTLE_LAST = WC_W'(SETTLE - 1);
    localparam logic [WC_W-1:0] MEAS_LAST = WC_W'(SETTLE + WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [WC_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    logic resp_q, resp_d;
    logic en_q, en_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic [1:0] sync_a_q, sync_b_q;
    logic hist_a_q, hist_b_q;
    logic edge_a, edge_b;
`ifdef RO_CMP_TIE_EN
    logic tie_q, tie_d;
`endif

    assign edge_a = sync_a_q[1] & ~hist_a_q;
    assign edge_b = sync_b_q[1] & ~hist_b_q;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        resp_d  = resp_q;
`ifdef RO_CMP_TIE_EN
        tie_d   = tie_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    win_d   = '0;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    resp_d  = 1'b0;
`ifdef RO_CMP_TIE_EN
                    tie_d   = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                win_d = win_q + 1'b1;
                if (win_q == SETTLE_LAST) state_d = S_MEASURE;
            end
            S_MEASURE: begin
                win_d = win_q + 1'b1;
                // Counters stick at all-ones rather than wrap
                if (edge_a && cnt_a_q != CNT_MAX) cnt_a_d = cnt_a_q + 1'b1;
                if (edge_b && cnt_b_q != CNT_MAX) cnt_b_d = cnt_b_q + 1'b1;
                if (win_q == MEAS_LAST) state_d = S_COMPARE;
            end
            S_COMPARE: begin
                resp_d  = cnt_a_q > cnt_b_q;
`ifdef RO_CMP_TIE_EN
                tie_d   = cnt_a_q == cnt_b_q;
`endif
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        en_d   = (state_d == S_SETTLE) || (state_d == S_MEASURE);
        busy_d = en_d || (state_d == S_COMPARE);
        done_d = state_d == S_DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            win_q    <= '0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            resp_q   <= 1'b0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sync_a_q <= '0;
            sync_b_q <= '0;
            hist_a_q <= 1'b0;
            hist_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            resp_q   <= resp_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sync_a_q <= {sync_a_q[0], ro_a};
            sync_b_q <= {sync_b_q[0], ro_b};
            hist_a_q <= sync_a_q[1];
            hist_b_q <= sync_b_q[1];
        end
    end

`ifdef RO_CMP_TIE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tie_q <= 1'b0;
        else tie_q <= tie_d;
    end
    assign tie = tie_q;
`endif

    assign ro_enable = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign response  = resp_q;
    assign count_a   = cnt_a_q;
    assign count_b   = cnt_b_q;

endmodule

// File: tb/tb_ro_pair_compare.sv
// Bench for ro_pair_compare: randomized RO periods/phases against an arithmetic edge-count model.
`timescale 1ns/1ps
module tb_ro_pair_compare;

    localparam int W = 64;
    localparam int S = 8;
    localparam int TCLK = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st1 = 1'b0;
    logic st2 = 1'b0;
    logic ra = 1'b0;
    logic rb = 1'b0;

    logic en1, busy1, done1, resp1;
    logic [15:0] ca1, cb1;
    logic en2, busy2, done2, resp2;
    logic [2:0] ca2, cb2;
`ifdef RO_CMP_TIE_EN
    logic tie1, tie2;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    longint per_a = 80, per_b = 160, ph_a = 0, ph_b = 0;
    bit same = 1'b0;

    ro_pair_compare #(.WINDOW(W), .SETTLE(S), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .start(st1), .ro_a(ra), .ro_b(rb),
        .ro_enable(en1), .busy(busy1), .done(done1), .response(resp1),
        .count_a(ca1), .count_b(cb1)
`ifdef RO_CMP_TIE_EN
        , .tie(tie1)
`endif
    );

    ro_pair_compare #(.WINDOW(W), .SETTLE(S), .CNT_W(3)) u2 (
        .clk(clk), .rst(rst), .start(st2), .ro_a(ra), .ro_b(rb),
        .ro_enable(en2), .busy(busy2), .done(done2), .response(resp2),
        .count_a(ca2), .count_b(cb2)
`ifdef RO_CMP_TIE_EN
        , .tie(tie2)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Free-running square waves derived from absolute time, period/phase set by tests
    always begin
        #1;
        ra = ((longint'($time) + ph_a) % per_a) < (per_a / 2);
        rb = same ? ra : (((longint'($time) + ph_b) % per_b) < (per_b / 2));
    end

    // Model: a window of W clocks sees W*TCLK/period edges, +-1
    function automatic bit in_range(input int c, input longint per);
        longint d;
        d = longint'(c) * per - longint'(W * TCLK);
        if (d < 0) d = -d;
        return d <= per;
    endfunction

    task automatic run(input int inst, input bit hold, output int lat,
                       output int en, output int ca, output int cb,
                       output bit rsp, output bit bsy);
        int c0;
        @(negedge clk);
        if (inst == 1) st1 = 1'b1; else st2 = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        if (!hold) begin
            st1 = 1'b0;
            st2 = 1'b0;
        end
        lat = -1;
        en = 0;
        ca = 0;
        cb = 0;
        rsp = 1'b0;
        bsy = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((inst == 1) ? en1 : en2) en++;
            if ((inst == 1) ? done1 : done2) begin
                lat = cyc - c0;
                ca = (inst == 1) ? int'(ca1) : int'(ca2);
                cb = (inst == 1) ? int'(cb1) : int'(cb2);
                rsp = (inst == 1) ? resp1 : resp2;
                bsy = (inst == 1) ? busy1 : busy2;
                break;
            end
        end
    endtask

    task automatic check_run(input string nm, input int lat, input int en,
                             input int ca, input int cb, input bit rsp,
                             input bit bsy, input bit exp_rsp);
        checks++;
        if (lat !== S + W + 1) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", nm, lat, S + W + 1);
        end
        checks++;
        if (en !== S + W) begin
            failures++;
            $display("FAIL %s enable cycles: got %0d want %0d", nm, en, S + W);
        end
        checks++;
        if (!in_range(ca, per_a)) begin
            failures++;
            $display("FAIL %s count_a: got %0d period %0d", nm, ca, per_a);
        end
        checks++;
        if (!in_range(cb, per_b)) begin
            failures++;
            $display("FAIL %s count_b: got %0d period %0d", nm, cb, per_b);
        end
        checks++;
        if (rsp !== exp_rsp) begin
            failures++;
            $display("FAIL %s response: got %0b want %0b", nm, rsp, exp_rsp);
        end
        checks++;
        if (bsy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy in done cycle: got %0b want 0", nm, bsy);
        end
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0) begin
            failures++;
            $display("FAIL %s done width: got %0b want 0", nm, done1);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({en1, busy1, done1, resp1} !== 4'b0) begin
            failures++;
            $display("FAIL reset flags: got %b want 0000", {en1, busy1, done1, resp1});
        end
        checks++;
        if ({ca1, cb1} !== 32'd0) begin
            failures++;
            $display("FAIL reset counts: got %0d/%0d want 0/0", ca1, cb1);
        end
`ifdef RO_CMP_TIE_EN
        checks++;
        if (tie1 !== 1'b0) begin
            failures++;
            $display("FAIL reset tie: got %0b want 0", tie1);
        end
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({en1, busy1, done1} !== 3'b0) begin
            failures++;
            $display("FAIL idle flags: got %b want 000", {en1, busy1, done1});
        end
    endtask

    task automatic test_pair(input string nm, input longint pa, input longint pb);
        int lat, en, ca, cb;
        bit rsp, bsy;
        per_a = pa;
        per_b = pb;
        ph_a = longint'($urandom_range(0, 159)) % pa;
        ph_b = longint'($urandom_range(0, 159)) % pb;
        run(1, 1'b0, lat, en, ca, cb, rsp, bsy);
        check_run(nm, lat, en, ca, cb, rsp, bsy, pa < pb);
`ifdef RO_CMP_TIE_EN
        checks++;
        if (tie1 !== 1'b0) begin
            failures++;
            $display("FAIL %s tie: got %0b want 0", nm, tie1);
        end
`endif
    endtask

    task automatic test_random();
        longint opts[3] = '{40, 80, 160};
        for (int i = 0; i < 4; i++) begin
            int x, y;
            x = $urandom_range(0, 2);
            y = (x + $urandom_range(1, 2)) % 3;
            test_pair("random", opts[x], opts[y]);
        end
    endtask

    task automatic test_tie();
        int lat, en, ca, cb;
        bit rsp, bsy;
        same = 1'b1;
        per_a = 100;
        per_b = 100;
        ph_a = longint'($urandom_range(0, 99));
        run(1, 1'b0, lat, en, ca, cb, rsp, bsy);
        checks++;
        if (ca !== cb || !in_range(ca, 100)) begin
            failures++;
            $display("FAIL tie counts: got %0d/%0d want equal near 6", ca, cb);
        end
        checks++;
        if (rsp !== 1'b0) begin
            failures++;
            $display("FAIL tie response: got %0b want 0", rsp);
        end
`ifdef RO_CMP_TIE_EN
        checks++;
        if (tie1 !== 1'b1) begin
            failures++;
            $display("FAIL tie flag: got %0b want 1", tie1);
        end
`endif
        same = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat, en, ca, cb, seen;
        bit rsp, bsy;
        per_a = 40;
        per_b = 80;
        @(negedge clk);
        st1 = 1'b1;
        @(posedge clk);
        #1;
        st1 = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({en1, busy1, done1, resp1} !== 4'b0 || {ca1, cb1} !== 32'd0) begin
            failures++;
            $display("FAIL mid reset: got en=%0b busy=%0b done=%0b rsp=%0b ca=%0d cb=%0d want all 0",
                     en1, busy1, done1, resp1, ca1, cb1);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done1 || busy1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL aborted run activity: got %0d cycles want 0", seen);
        end
        test_pair("after_reset", 80, 160);
    endtask

    task automatic test_saturation();
        int lat, en, ca, cb;
        bit rsp, bsy;
        per_a = 40;
        per_b = 160;
        ph_a = longint'($urandom_range(0, 39));
        run(2, 1'b0, lat, en, ca, cb, rsp, bsy);
        checks++;
        if (ca !== 7) begin
            failures++;
            $display("FAIL saturation count_a: got %0d want 7", ca);
        end
        checks++;
        if (!in_range(cb, 160) || rsp !== 1'b1) begin
            failures++;
            $display("FAIL saturation count_b/resp: got %0d/%0b want ~4/1", cb, rsp);
        end
    endtask

    task automatic test_back_to_back();
        int c0, d1, d2, lat;
        bit ok;
        per_a = 40;
        per_b = 160;
        @(negedge clk);
        st2 = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        st2 = 1'b0;
        d1 = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 30) st2 = 1'b1;
            if (i == 31) st2 = 1'b0;
            if (i == 71) st2 = 1'b1;
            if (done2) begin
                d1 = cyc;
                break;
            end
        end
        checks++;
        if (d1 - c0 !== S + W + 1) begin
            failures++;
            $display("FAIL ignored start latency: got %0d want %0d", d1 - c0, S + W + 1);
        end
        @(negedge clk);
        st2 = 1'b0;
        ok = en2 && busy2;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL back_to_back restart: got en=%0b busy=%0b want 1/1", en2, busy2);
        end
        d2 = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done2) begin
                d2 = cyc;
                break;
            end
        end
        lat = d2 - d1;
        checks++;
        if (lat !== S + W + 2) begin
            failures++;
            $display("FAIL back_to_back spacing: got %0d want %0d", lat, S + W + 2);
        end
        checks++;
        if (ca2 !== 3'd7) begin
            failures++;
            $display("FAIL back_to_back count_a: got %0d want 7", ca2);
        end
    endtask

    initial begin
        test_reset();
        test_pair("fast_a", 80, 160);
        test_pair("swapped", 160, 80);
        test_random();
        test_tie();
        test_reset_mid();
        test_saturation();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
